lane_rotator: RTL and testbench
===============================

LANE_ROTATOR -- requirements
Module: lane_rotator

Interface
REQ-001 SHALL have parameter LANE_W, default 64, giving lane width in bits (power of two, >=8).
REQ-002 SHALL have parameter DIM, default 5, giving the lane matrix dimension; the block handles DIM*DIM lanes (N).
REQ-003 SHALL have parameter STEP, default 1, giving the maximum bits rotated per cycle (power of two, <= LANE_W).
REQ-004 Ports, in order (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- mode  in  2  00 rotl, 01 rotr, 10 logical shl (zero fill), 11 bypass; sampled with start.
- in_valid  in  1  data_in holds a lane.
- in_ready  out  1  block accepts a lane this cycle.
- data_in  in  LANE_W  input lane.
- out_valid  out  1  data_out holds a result lane.
- out_ready  in  1  consumer accepts data_out.
- data_out  out  LANE_W  result lane.
- one_done  out  1  one-cycle pulse per lane finished in ROT.
- done  out  1  one-cycle pulse after the last lane is emitted.
- busy  out  1  state != IDLE.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, ROT, EMIT; lane index idx (0..N-1, row-major idx=i*DIM+j) and step counter k are shared across states.
REQ-006 IDLE: start=1 -> LOAD, latch mode, idx=0; start in any other state SHALL be ignored.
REQ-007 LOAD: in_ready=1; on in_valid&in_ready store data_in to buffer[idx], idx++; on acceptance of lane N-1 -> ROT with idx=0, k=0.
REQ-008 Offset per lane: off(idx) = (idx*(idx+1)/2) mod LANE_W; mode 11 SHALL use offset 0 for every lane.
REQ-009 ROT: lane idx SHALL occupy max(1, ceil(off/STEP)) cycles; each cycle moves by min(STEP, remaining) bits in the mode's direction and writes back to buffer[idx].
REQ-010 one_done SHALL pulse in the last ROT cycle of each lane, i.e. N pulses per job; on the last cycle of lane N-1 -> EMIT with idx=0.
REQ-011 Shift mode SHALL give exactly lane << off with zero fill; rotate modes SHALL be exact modulo-LANE_W rotations.
REQ-012 EMIT: out_valid=1, data_out=buffer[idx]; on out_valid&out_ready idx++; data_out SHALL hold stable while out_ready=0.
REQ-013 On handshake of lane N-1: done=1 the next cycle, state -> IDLE in that same cycle.
REQ-014 data_out SHALL be 0 whenever out_valid=0; in_ready SHALL be 0 outside LOAD.
REQ-015 in_valid outside LOAD SHALL be ignored with no state change.

Reset
REQ-016 rst=0 SHALL, asynchronously, force state IDLE, idx=0, k=0, mode=00, and in_ready, out_valid, one_done, done, busy=0, data_out=0.
REQ-017 Reset asserted mid-job (any state) SHALL abort the job; buffer contents need not be cleared; no done pulse SHALL follow.
REQ-018 After reset release, the first rising edge with start=1 SHALL start a fresh job.

Verification (LANE_W=8, DIM=2, STEP=1 unless stated; offsets 0,1,3,6)
REQ-019 Lanes 81,81,81,81 hex, mode 00 -> outputs 81,03,0C,60; ROT lasts 11 cycles; 4 one_done pulses; 1 done pulse.
REQ-020 Same input, mode 01 -> 81,C0,30,06; mode 10 -> 81,02,08,40; mode 11 -> 81,81,81,81 with ROT lasting 4 cycles.
REQ-021 STEP=4, mode 00, same input -> outputs 81,03,0C,60; ROT lasts 5 cycles (1,1,1,2).
REQ-022 EMIT with out_ready low 3 cycles per lane -> data_out stable while stalled, order preserved, done only after the 4th handshake.
REQ-023 rst low during ROT lane 2 -> all outputs 0 immediately, busy=0, no done; a new start then runs a full job correctly.
REQ-024 start pulsed during LOAD and EMIT, in_valid high in ROT -> ignored; results identical to REQ-019.

Source files
------------

// File: rtl/lane_rotator_if.sv
// lane_rotator_if: input-lane and output-lane valid/ready streams of the lane rotator
interface lane_rotator_if #(parameter int LANE_W = 64);
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] data_out;
  modport master (output in_valid, data_in, out_ready, input in_ready, out_valid, data_out);
  modport slave  (input in_valid, data_in, out_ready, output in_ready, out_valid, data_out);
endinterface

// File: rtl/lane_rotator.sv
// lane_rotator: loads DIM*DIM lanes, rotates/shifts lane idx by idx*(idx+1)/2 at up to STEP bits per cycle, then emits them
module lane_rotator #(
  parameter int LANE_W = 64,
  parameter int DIM    = 5,
  parameter int STEP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  lane_rotator_if.slave bus,
  output logic       one_done,
  output logic       done,
  output logic       busy
);
  localparam int N  = DIM * DIM;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int KW = $clog2(LANE_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, ROT, EMIT} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [KW-1:0]     k_q, k_d;
  logic [1:0]        mode_q, mode_d;
  logic              done_q, done_d;
  logic [LANE_W-1:0] buf_q [N];
  logic [LANE_W-1:0] buf_d [N];
  logic [LANE_W-1:0] cur, rot;
  logic              last, last_lane;
  int                off, rem, amt;
  always_comb begin
    off = mode_q == 2'b11 ? 0 : ((int'(idx_q) * (int'(idx_q) + 1)) / 2) % LANE_W;
    rem = off - int'(k_q) * STEP;
    amt = rem < STEP ? rem : STEP;
    last = rem <= STEP;
    last_lane = idx_q == IW'(N - 1);
    cur = buf_q[idx_q];
    rot = mode_q == 2'b00 ? (cur << amt) | (cur >> (LANE_W - amt)) :
          mode_q == 2'b01 ? (cur >> amt) | (cur << (LANE_W - amt)) :
          mode_q == 2'b10 ? cur << amt : cur;
    state_d = state_q;
    idx_d = idx_q;
    k_d = k_q;
    mode_d = mode_q;
    done_d = 1'b0;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        mode_d = mode;
        idx_d = '0;
      end
      LOAD: if (bus.in_valid) begin
        buf_d[idx_q] = bus.data_in;
        idx_d = last_lane ? '0 : idx_q + IW'(1);
        k_d = '0;
        state_d = last_lane ? ROT : LOAD;
      end
      ROT: begin
        buf_d[idx_q] = rot;
        k_d = last ? '0 : k_q + KW'(1);
        idx_d = !last ? idx_q : last_lane ? '0 : idx_q + IW'(1);
        state_d = last && last_lane ? EMIT : ROT;
      end
      EMIT: if (bus.out_ready) begin
        idx_d = last_lane ? '0 : idx_q + IW'(1);
        done_d = last_lane;
        state_d = last_lane ? IDLE : EMIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      k_q <= '0;
      mode_q <= 2'b00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      k_q <= k_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  always_ff @(posedge clk) buf_q <= buf_d;
  assign bus.in_ready  = state_q == LOAD;
  assign bus.out_valid = state_q == EMIT;
  assign bus.data_out  = state_q == EMIT ? cur : '0;
  assign one_done      = state_q == ROT && last;
  assign done          = done_q;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_lane_rotator.sv
// tb_lane_rotator: directed checks of lane_rotator with STEP=1 (dut a) and STEP=4 (dut b)
module tb_lane_rotator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] mode = 2'b00;
  logic sel = 1'b0;
  logic one_done_a, done_a, busy_a, one_done_b, done_b, busy_b;
  int checks = 0, failures = 0;
  lane_rotator_if #(.LANE_W(8)) a ();
  lane_rotator_if #(.LANE_W(8)) b ();
  assign b.in_valid  = a.in_valid;
  assign b.data_in   = a.data_in;
  assign b.out_ready = a.out_ready;
  lane_rotator #(.LANE_W(8), .DIM(2), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode), .bus(a),
    .one_done(one_done_a), .done(done_a), .busy(busy_a));
  lane_rotator #(.LANE_W(8), .DIM(2), .STEP(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode), .bus(b),
    .one_done(one_done_b), .done(done_b), .busy(busy_b));
  always #5 clk = ~clk;
  wire       in_ready_s  = sel ? b.in_ready  : a.in_ready;
  wire       out_valid_s = sel ? b.out_valid : a.out_valid;
  wire [7:0] data_out_s  = sel ? b.data_out  : a.data_out;
  wire       one_done_s  = sel ? one_done_b  : one_done_a;
  wire       done_s      = sel ? done_b      : done_a;
  wire       busy_s      = sel ? busy_b      : busy_a;
  task automatic run_job(input bit s, input logic [1:0] m, input logic [31:0] lanes, input logic [31:0] exp,
                         input int rot_exp, input bit stall, input bit disturb);
    int rc, od;
    sel = s;
    @(negedge clk);
    start_a = !s;
    start_b = s;
    mode = m;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy_s, in_ready_s, out_valid_s} !== 3'b110) begin
        failures++;
        $display("FAIL load_ready lane %0d: busy/in_ready/out_valid=%b want 110", i, {busy_s, in_ready_s, out_valid_s});
      end
      a.in_valid = 1'b1;
      a.data_in = lanes[8*i +: 8];
      start_a = disturb && i == 1;
      @(negedge clk);
    end
    a.in_valid = disturb;
    a.data_in = 8'hFF;
    start_a = 1'b0;
    rc = 0;
    od = 0;
    while (busy_s && !out_valid_s && rc < 200) begin
      checks++;
      if ({in_ready_s, data_out_s} !== 9'h0) begin
        failures++;
        $display("FAIL rot_idle_outputs cycle %0d: in_ready=%b data_out=%h want 0/00", rc, in_ready_s, data_out_s);
      end
      if (one_done_s) od++;
      rc++;
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    checks++;
    if (rc !== rot_exp) begin
      failures++;
      $display("FAIL rot_cycles mode %b: got %0d want %0d", m, rc, rot_exp);
    end
    checks++;
    if (od !== 4) begin
      failures++;
      $display("FAIL one_done_count mode %b: got %0d want 4", m, od);
    end
    for (int i = 0; i < 4; i++) begin
      if (stall) repeat (3) begin
        a.out_ready = 1'b0;
        checks++;
        if ({out_valid_s, data_out_s} !== {1'b1, exp[8*i +: 8]}) begin
          failures++;
          $display("FAIL stall_hold lane %0d: valid/data=%b/%h want 1/%h", i, out_valid_s, data_out_s, exp[8*i +: 8]);
        end
        @(negedge clk);
      end
      checks++;
      if ({out_valid_s, data_out_s, done_s} !== {1'b1, exp[8*i +: 8], 1'b0}) begin
        failures++;
        $display("FAIL emit lane %0d mode %b: valid/data/done=%b/%h/%b want 1/%h/0", i, m, out_valid_s, data_out_s, done_s, exp[8*i +: 8]);
      end
      start_a = disturb && i == 0;
      a.out_ready = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      a.out_ready = 1'b0;
    end
    checks++;
    if ({done_s, busy_s, out_valid_s, data_out_s} !== {3'b100, 8'h00}) begin
      failures++;
      $display("FAIL done_pulse mode %b: done/busy/valid/data=%b/%b/%b/%h want 1/0/0/00", m, done_s, busy_s, out_valid_s, data_out_s);
    end
    @(negedge clk);
    checks++;
    if ({done_s, busy_s} !== 2'b00) begin
      failures++;
      $display("FAIL done_width mode %b: done/busy=%b/%b want 0/0", m, done_s, busy_s);
    end
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({a.in_ready, a.out_valid, a.data_out, one_done_a, done_a, busy_a} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready/valid/data/one_done/done/busy=%b/%b/%h/%b/%b/%b want all 0",
               a.in_ready, a.out_valid, a.data_out, one_done_a, done_a, busy_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_a, busy_b, done_a, done_b} !== 4'b0) begin
      failures++;
      $display("FAIL post_reset_idle: busy_a/busy_b/done_a/done_b=%b want 0000", {busy_a, busy_b, done_a, done_b});
    end
  endtask
  task automatic test_modes();
    run_job(1'b0, 2'b00, 32'h81818181, 32'h600C0381, 11, 1'b0, 1'b0);
    run_job(1'b0, 2'b01, 32'h81818181, 32'h0630C081, 11, 1'b0, 1'b0);
    run_job(1'b0, 2'b10, 32'h81818181, 32'h40080281, 11, 1'b0, 1'b0);
    run_job(1'b0, 2'b11, 32'h81818181, 32'h81818181, 4, 1'b0, 1'b0);
    run_job(1'b0, 2'b00, 32'hA5F08001, 32'h69870101, 11, 1'b0, 1'b0);
    run_job(1'b0, 2'b10, 32'hA5F08001, 32'h40800001, 11, 1'b0, 1'b0);
  endtask
  task automatic test_step4();
    run_job(1'b1, 2'b00, 32'h81818181, 32'h600C0381, 5, 1'b0, 1'b0);
  endtask
  task automatic test_stall();
    run_job(1'b0, 2'b00, 32'h81818181, 32'h600C0381, 11, 1'b1, 1'b0);
  endtask
  task automatic test_ignored_inputs();
    run_job(1'b0, 2'b00, 32'h81818181, 32'h600C0381, 11, 1'b0, 1'b1);
  endtask
  task automatic test_abort();
    sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    mode = 2'b00;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a.in_valid = 1'b1;
      a.data_in = 8'h81;
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({a.in_ready, a.out_valid, a.data_out, one_done_a, done_a, busy_a} !== 13'h0) begin
      failures++;
      $display("FAIL abort_outputs: ready/valid/data/one_done/done/busy=%b/%b/%h/%b/%b/%b want all 0",
               a.in_ready, a.out_valid, a.data_out, one_done_a, done_a, busy_a);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({done_a, busy_a} !== 2'b00) begin
        failures++;
        $display("FAIL abort_no_done cycle %0d: done/busy=%b/%b want 0/0", i, done_a, busy_a);
      end
      @(negedge clk);
    end
    run_job(1'b0, 2'b00, 32'h81818181, 32'h600C0381, 11, 1'b0, 1'b0);
  endtask
  initial begin
    a.in_valid = 1'b0;
    a.data_in = 8'h00;
    a.out_ready = 1'b0;
    test_reset();
    test_modes();
    test_step4();
    test_stall();
    test_ignored_inputs();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
